// File: rtl/uart_rx_frame.sv
// UART receiver with 2-FF input synchroniser, three-sample majority voting,
// parity/framing/overrun flags and a valid/ack output holding register.
module uart_rx_frame #(
   parameter int CLKS_PER_BIT = 10417,
   parameter int DATA_BITS    = 8,
   parameter int PARITY       = 0,
   parameter int STOP_BITS    = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 serial_in,
   output logic [DATA_BITS-1:0] data,
   output logic                 drdy,
   input  logic                 data_ack,
   output logic                 parity_err,
   output logic                 frame_err,
   output logic                 overrun,
   output logic                 busy
);

   localparam int CW  = $clog2(CLKS_PER_BIT);
   localparam int MID = CLKS_PER_BIT / 2;
   localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] CNT_S0   = CW'(MID - 1);
   localparam logic [CW-1:0] CNT_S1   = CW'(MID);
   localparam logic [CW-1:0] CNT_S2   = CW'(MID + 1);
   localparam logic          ODD_EXP  = (PARITY == 1);

   typedef enum logic [2:0] {
      S_IDLE, S_START, S_DATA, S_PAR, S_STOP, S_DELIVER, S_BRK
   } state_t;

   state_t                 state, state_n;
   logic                   sync1, rx_s, rx_prev;
   logic [CW-1:0]          cnt;
   logic                   s0, s1, vote, at_vote, counting;
   logic [3:0]             bit_idx;
   logic [DATA_BITS-1:0]   shreg;
   logic                   par_bit, ferr, perr_c;

   // Third sample is the live rx_s on the vote cycle itself.
   assign vote     = (s0 & s1) | (s0 & rx_s) | (s1 & rx_s);
   assign counting = (state == S_START) || (state == S_DATA) ||
                     (state == S_PAR)   || (state == S_STOP);
   assign at_vote  = counting && (cnt == CNT_S2);
   assign perr_c   = (PARITY != 0) && ((^shreg ^ par_bit) != ODD_EXP);
   assign busy     = (state != S_IDLE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_IDLE;
      else     state <= state_n;
   end

   always_comb begin
      state_n = state;
      unique case (state)
         S_IDLE:    if (rx_prev && !rx_s) state_n = S_START;
         S_START:   if (at_vote) state_n = vote ? S_IDLE : S_DATA;
         S_DATA:    if (at_vote && bit_idx == 4'(DATA_BITS - 1))
                       state_n = (PARITY != 0) ? S_PAR : S_STOP;
         S_PAR:     if (at_vote) state_n = S_STOP;
         S_STOP:    if (at_vote && bit_idx == 4'(STOP_BITS - 1)) state_n = S_DELIVER;
         S_DELIVER: state_n = rx_s ? S_IDLE : S_BRK;
         S_BRK:     if (rx_s) state_n = S_IDLE;
         default:   state_n = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1   <= 1'b1;
         rx_s    <= 1'b1;
         rx_prev <= 1'b1;
         cnt     <= '0;
         s0      <= 1'b1;
         s1      <= 1'b1;
         bit_idx <= '0;
         shreg   <= '0;
         par_bit <= 1'b0;
         ferr    <= 1'b0;
      end else begin
         sync1   <= serial_in;
         rx_s    <= sync1;
         rx_prev <= rx_s;
         if (!counting)             cnt <= '0;
         else if (cnt == CNT_LAST)  cnt <= '0;
         else                       cnt <= cnt + CW'(1);
         if (cnt == CNT_S0) s0 <= rx_s;
         if (cnt == CNT_S1) s1 <= rx_s;
         // Bit index restarts on every state change so it serves DATA and STOP.
         if (state_n != state) bit_idx <= '0;
         else if (at_vote)     bit_idx <= bit_idx + 4'd1;
         if (state == S_START) ferr <= 1'b0;
         if (at_vote) begin
            case (state)
               S_DATA:  shreg   <= {vote, shreg[DATA_BITS-1:1]};
               S_PAR:   par_bit <= vote;
               S_STOP:  ferr    <= ferr | ~vote;
               default: ;
            endcase
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         data       <= '0;
         drdy       <= 1'b0;
         parity_err <= 1'b0;
         frame_err  <= 1'b0;
         overrun    <= 1'b0;
      end else if (state == S_DELIVER) begin
         if (!drdy || data_ack) begin
            data       <= shreg;
            parity_err <= perr_c;
            frame_err  <= ferr;
            drdy       <= 1'b1;
            overrun    <= 1'b0;
         end else begin
            overrun <= 1'b1;
         end
      end else if (drdy && data_ack) begin
         drdy    <= 1'b0;
         overrun <= 1'b0;
      end
   end

endmodule

// File: tb/tb_uart_rx_frame.sv
// Bench for uart_rx_frame: three configurations (8N1, 8E1, 7O2) driven with
// randomized frames and compared against a bit-level reference model.
module tb_uart_rx_frame;

   localparam int CPB = 16;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [2:0] line = 3'b111;
   logic [2:0] ack  = 3'b000;
   logic [2:0] drdy_v, perr_v, ferr_v, ovr_v, busy_v;
   logic [7:0] data_a, data_b;
   logic [6:0] data_c;

   int n_cmp = 0;
   int n_err = 0;
   logic [10:0] exp_q[$];   // {parity_err, frame_err, data[8:0]}

   always #5 clk = ~clk;

   uart_rx_frame #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_a (
      .clk(clk), .rst(rst), .serial_in(line[0]), .data(data_a), .drdy(drdy_v[0]),
      .data_ack(ack[0]), .parity_err(perr_v[0]), .frame_err(ferr_v[0]),
      .overrun(ovr_v[0]), .busy(busy_v[0]));

   uart_rx_frame #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_b (
      .clk(clk), .rst(rst), .serial_in(line[1]), .data(data_b), .drdy(drdy_v[1]),
      .data_ack(ack[1]), .parity_err(perr_v[1]), .frame_err(ferr_v[1]),
      .overrun(ovr_v[1]), .busy(busy_v[1]));

   uart_rx_frame #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY(1), .STOP_BITS(2)) u_c (
      .clk(clk), .rst(rst), .serial_in(line[2]), .data(data_c), .drdy(drdy_v[2]),
      .data_ack(ack[2]), .parity_err(perr_v[2]), .frame_err(ferr_v[2]),
      .overrun(ovr_v[2]), .busy(busy_v[2]));

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_cmp++;
      if (got !== want) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, want);
      end
   endtask

   function automatic logic [8:0] dout(input int idx);
      case (idx)
         0:       return {1'b0, data_a};
         1:       return {1'b0, data_b};
         default: return {2'b00, data_c};
      endcase
   endfunction

   // Reference: expected output word from the frame as it appears on the line.
   function automatic logic [10:0] model(input int nbits, input int pmode, input int nstop,
                                         input logic [8:0] d, input logic pbit,
                                         input logic [1:0] stops);
      logic [8:0] mask;
      int         ones;
      logic       perr, ferr;
      mask = 9'((1 << nbits) - 1);
      ones = $countones(d & mask);
      perr = (pmode == 0) ? 1'b0 : (((ones + int'(pbit)) % 2) != ((pmode == 1) ? 1 : 0));
      ferr = (stops[0] == 1'b0) || (nstop == 2 && stops[1] == 1'b0);
      return {perr, ferr, d & mask};
   endfunction

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic send_bit(input int idx, input logic b, input int glitch_at);
      for (int c = 0; c < CPB; c++) begin
         @(negedge clk);
         line[idx] = (c == glitch_at) ? ~b : b;
      end
   endtask

   task automatic send_frame(input int idx, input int nbits, input int pmode, input int nstop,
                             input logic [8:0] d, input logic pbit, input logic [1:0] stops,
                             input int glitch_bit);
      send_bit(idx, 1'b0, -1);
      for (int i = 0; i < nbits; i++) send_bit(idx, d[i], (i == glitch_bit) ? 9 : -1);
      if (pmode != 0) send_bit(idx, pbit, -1);
      for (int s = 0; s < nstop; s++) send_bit(idx, stops[s], -1);
   endtask

   task automatic send_exp(input int idx, input int nbits, input int pmode, input int nstop,
                           input logic [8:0] d, input logic pbit, input logic [1:0] stops,
                           input int glitch_bit);
      exp_q.push_back(model(nbits, pmode, nstop, d, pbit, stops));
      send_frame(idx, nbits, pmode, nstop, d, pbit, stops, glitch_bit);
      line[idx] = 1'b1;
   endtask

   task automatic expect_word(input int idx, input string tag);
      int          t;
      logic [10:0] e;
      t = 0;
      while (!drdy_v[idx] && t < 50 * CPB) begin
         @(negedge clk);
         t++;
      end
      check({tag, "_drdy"}, 32'(drdy_v[idx]), 32'd1);
      check({tag, "_pending"}, 32'(exp_q.size() != 0), 32'd1);
      if (drdy_v[idx] && exp_q.size() != 0) begin
         e = exp_q.pop_front();
         check({tag, "_data"}, 32'(dout(idx)), 32'(e[8:0]));
         check({tag, "_perr"}, 32'(perr_v[idx]), 32'(e[10]));
         check({tag, "_ferr"}, 32'(ferr_v[idx]), 32'(e[9]));
      end
      ack[idx] = 1'b1;
      @(negedge clk);
      ack[idx] = 1'b0;
      check({tag, "_drdy_clr"}, 32'(drdy_v[idx]), 32'd0);
      check({tag, "_ovr_clr"}, 32'(ovr_v[idx]), 32'd0);
   endtask

   initial begin
      logic [8:0] d;
      logic       pb;
      logic [1:0] st;
      int         g;

      idle(5);
      check("rst_drdy", 32'(drdy_v), 32'd0);
      check("rst_busy", 32'(busy_v), 32'd0);
      check("rst_perr", 32'(perr_v), 32'd0);
      check("rst_ferr", 32'(ferr_v), 32'd0);
      check("rst_ovr", 32'(ovr_v), 32'd0);
      check("rst_data", {8'd0, data_a, data_b, 1'b0, data_c}, 32'd0);
      rst = 1'b0;
      idle(2 * CPB);

      // 8N1 basic and randomized, with single-clock mid-bit glitches
      send_exp(0, 8, 0, 1, 9'h0A5, 1'b0, 2'b11, -1);
      expect_word(0, "a5");
      for (int k = 0; k < 6; k++) begin
         d = 9'($urandom_range(0, 255));
         g = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 7)) : -1;
         send_exp(0, 8, 0, 1, d, 1'b0, 2'b11, g);
         idle($urandom_range(0, 20));
         expect_word(0, "rand_8n1");
      end

      // even parity
      send_exp(1, 8, 2, 1, 9'h007, 1'b0, 2'b11, -1);
      expect_word(1, "par07_p0");
      send_exp(1, 8, 2, 1, 9'h007, 1'b1, 2'b11, -1);
      expect_word(1, "par07_p1");
      for (int k = 0; k < 6; k++) begin
         d  = 9'($urandom_range(0, 255));
         pb = 1'($urandom_range(0, 1));
         send_exp(1, 8, 2, 1, d, pb, 2'b11, -1);
         expect_word(1, "rand_8e1");
      end

      // framing error followed by a long break
      exp_q.push_back(model(8, 0, 1, 9'h03C, 1'b0, 2'b00));
      send_frame(0, 8, 0, 1, 9'h03C, 1'b0, 2'b00, -1);
      expect_word(0, "break");
      idle(38 * CPB);
      check("break_no_drdy", 32'(drdy_v[0]), 32'd0);
      check("break_busy", 32'(busy_v[0]), 32'd1);
      line[0] = 1'b1;
      idle(2 * CPB);
      check("break_idle", 32'(busy_v[0]), 32'd0);
      check("break_no_drdy2", 32'(drdy_v[0]), 32'd0);
      send_exp(0, 8, 0, 1, 9'h05A, 1'b0, 2'b11, -1);
      expect_word(0, "after_break");

      // overrun: second word lost while the first is held
      send_exp(0, 8, 0, 1, 9'h011, 1'b0, 2'b11, -1);
      send_frame(0, 8, 0, 1, 9'h022, 1'b0, 2'b11, -1);
      idle(4);
      check("ovr_set", 32'(ovr_v[0]), 32'd1);
      check("ovr_held", 32'(data_a), 32'h11);
      expect_word(0, "ovr");

      // short start glitch is rejected
      line[0] = 1'b0;
      idle(4);
      line[0] = 1'b1;
      idle(3 * CPB);
      check("glitch_drdy", 32'(drdy_v[0]), 32'd0);
      check("glitch_busy", 32'(busy_v[0]), 32'd0);

      // reset in the middle of a frame
      send_bit(0, 1'b0, -1);
      for (int i = 0; i < 4; i++) send_bit(0, (i % 2) == 0, -1);
      check("mid_busy", 32'(busy_v[0]), 32'd1);
      rst = 1'b1;
      line[0] = 1'b1;
      idle(3);
      check("mid_rst_busy", 32'(busy_v[0]), 32'd0);
      rst = 1'b0;
      idle(2 * CPB);
      check("mid_rst_drdy", 32'(drdy_v[0]), 32'd0);
      send_exp(0, 8, 0, 1, 9'h081, 1'b0, 2'b11, -1);
      expect_word(0, "after_rst");
      idle(2 * CPB);
      check("after_rst_quiet", 32'(drdy_v[0]), 32'd0);

      // 7 data bits, odd parity, two stop bits
      send_exp(2, 7, 1, 2, 9'h07F, 1'b0, 2'b11, -1);
      expect_word(2, "c7f");
      for (int k = 0; k < 8; k++) begin
         d  = 9'($urandom_range(0, 127));
         pb = 1'($urandom_range(0, 1));
         st = (k % 3 == 1) ? 2'b10 : ((k % 3 == 2) ? 2'b01 : 2'b11);
         send_exp(2, 7, 1, 2, d, pb, st, -1);
         idle(2);
         expect_word(2, "rand_7o2");
      end

      check("queue_empty", 32'(exp_q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      n_err++;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $fatal(1, "watchdog");
   end

endmodule
